// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin bursty sharing of one FIFO write port among N requesters.
// Optional FIFO_ARB_GRANT_CNT_EN adds a 16-bit count of bursts that wrote at least one entry.
module fifo_write_arbiter #(
  parameter int N     = 4,
  parameter int width = 8,
  parameter int BURST = 4
) (
  input  logic               clock,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*width-1:0] req_data,
  output logic [N-1:0]       grant,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [width-1:0]   fifo_wdata,
  output logic               busy
`ifdef FIFO_ARB_GRANT_CNT_EN
  ,output logic [15:0]       grant_cnt
`endif
);
  localparam int OW = $clog2(N);
  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t        state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_owner_q, last_owner_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] pick;
  logic          found;
  logic          release_w;
`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [15:0]   grant_cnt_q, grant_cnt_d;
  assign grant_cnt = grant_cnt_q;
`endif

  assign busy       = state_q == ST_BURST;
  assign grant      = grant_q;
  assign fifo_write = busy && req[owner_q] && !fifo_full;
  assign fifo_wdata = busy ? req_data[owner_q*width +: width] : '0;

  // first requester at or after last_owner+1, wrapping mod N
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (int'(last_owner_q) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  // next-state: grant from IDLE, count beats, stall on full, release on last beat or req drop
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    grant_d      = grant_q;
    release_w    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (found && !fifo_full) begin
        owner_d    = pick;
        grant_d    = N'(1) << pick;
        beat_cnt_d = '0;
        state_d    = ST_BURST;
      end
    end else if (!req[owner_q] || (!fifo_full && beat_cnt_q == BW'(BURST - 1))) begin
      release_w    = 1'b1;
      state_d      = ST_IDLE;
      grant_d      = '0;
      last_owner_d = owner_q;
    end else if (!fifo_full) begin
      beat_cnt_d = beat_cnt_q + BW'(1);
    end
`ifdef FIFO_ARB_GRANT_CNT_EN
    grant_cnt_d = grant_cnt_q;
    if (release_w && (fifo_write || beat_cnt_q != '0))
      grant_cnt_d = grant_cnt_q + 16'd1;
`endif
  end

  // state registers with asynchronous active-low reset; requester 0 wins first
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_owner_q <= OW'(N - 1);
      beat_cnt_q   <= '0;
      grant_q      <= '0;
`ifdef FIFO_ARB_GRANT_CNT_EN
      grant_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      grant_q      <= grant_d;
`ifdef FIFO_ARB_GRANT_CNT_EN
      grant_cnt_q  <= grant_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of grant rotation, burst length, stalls and reset.
module tb_fifo_write_arbiter;
  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
  logic [3:0]  grant;
  logic        fifo_full = 1'b0;
  logic        fifo_write;
  logic [7:0]  fifo_wdata;
  logic        busy;
  logic [7:0]  dat [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
  int tests = 0;
  int fails = 0;
`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
`endif

  fifo_write_arbiter #(.N(4), .width(8), .BURST(4)) dut (
    .clock(clock), .rst(rst), .req(req), .req_data(req_data), .grant(grant),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_wdata(fifo_wdata), .busy(busy)
`ifdef FIFO_ARB_GRANT_CNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({grant, busy, fifo_write} !== 6'b0) begin
      fails++;
      $display("FAIL reset: grant=%b busy=%b write=%b, want all 0", grant, busy, fifo_write);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    step();
    tests++;
    if (grant !== 4'b0001) begin fails++; $display("FAIL single_grant: grant=%b want 0001", grant); end
    for (int b = 0; b < 4; b++) begin
      tests++;
      if (!(fifo_write === 1'b1 && fifo_wdata === 8'hA0 && grant === 4'b0001)) begin
        fails++;
        $display("FAIL single_beat%0d: write=%b data=%h grant=%b want 1 a0 0001", b, fifo_write, fifo_wdata, grant);
      end
      step();
    end
    tests++;
    if (grant !== 4'b0 || fifo_write !== 1'b0) begin
      fails++;
      $display("FAIL single_gap: grant=%b write=%b want 0000 0", grant, fifo_write);
    end
    step();
    tests++;
    if (grant !== 4'b0001) begin fails++; $display("FAIL single_regrant: grant=%b want 0001", grant); end
    req = 4'b0000;
    #1;
    tests++;
    if (fifo_write !== 1'b0) begin fails++; $display("FAIL single_drop_write: write=%b want 0", fifo_write); end
    step();
    tests++;
    if (grant !== 4'b0) begin fails++; $display("FAIL single_drop_release: grant=%b want 0000", grant); end
  endtask

  task automatic test_round_robin();
    int writes;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step();
      tests++;
      if (grant !== 4'(1 << (g % 4))) begin
        fails++;
        $display("FAIL rr_grant%0d: grant=%b want %b", g, grant, 4'(1 << (g % 4)));
      end
      writes = 0;
      for (int b = 0; b < 4; b++) begin
        if (fifo_write === 1'b1 && fifo_wdata === dat[g % 4]) writes++;
        step();
      end
      tests++;
      if (writes != 4 || grant !== 4'b0) begin
        fails++;
        $display("FAIL rr_burst%0d: writes=%0d grant=%b want 4 0000", g, writes, grant);
      end
    end
    req = 4'b0000;
`ifdef FIFO_ARB_GRANT_CNT_EN
    tests++;
    if (grant_cnt !== 16'd5) begin fails++; $display("FAIL rr_grant_cnt: %0d want 5", grant_cnt); end
`endif
  endtask

  task automatic test_drop();
    int writes = 0;
    do_reset();
    req = 4'b1100;
    step();
    tests++;
    if (grant !== 4'b0100) begin fails++; $display("FAIL drop_grant: grant=%b want 0100", grant); end
    for (int b = 0; b < 2; b++) begin
      if (fifo_write === 1'b1 && fifo_wdata === 8'hC2) writes++;
      step();
    end
    req = 4'b1000;
    #1;
    if (fifo_write === 1'b1) writes++;
    tests++;
    if (writes != 2) begin fails++; $display("FAIL drop_writes: writes=%0d want 2", writes); end
    step();
    tests++;
    if (grant !== 4'b0 || busy !== 1'b0) begin fails++; $display("FAIL drop_release: grant=%b busy=%b want 0000 0", grant, busy); end
    step();
    tests++;
    if (grant !== 4'b1000 || fifo_wdata !== 8'hD3) begin
      fails++;
      $display("FAIL drop_next: grant=%b data=%h want 1000 d3", grant, fifo_wdata);
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_stall();
    int writes = 0;
    do_reset();
    req = 4'b0001;
    step();
    tests++;
    if (fifo_write !== 1'b1) begin fails++; $display("FAIL stall_first: write=%b want 1", fifo_write); end
    step();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      tests++;
      if (fifo_write !== 1'b0 || grant !== 4'b0001 || busy !== 1'b1) begin
        fails++;
        $display("FAIL stall_hold%0d: write=%b grant=%b busy=%b want 0 0001 1", s, fifo_write, grant, busy);
      end
      step();
    end
    fifo_full = 1'b0;
    #1;
    for (int b = 0; b < 3; b++) begin
      if (fifo_write === 1'b1 && grant === 4'b0001) writes++;
      step();
    end
    tests++;
    if (writes != 3 || grant !== 4'b0) begin
      fails++;
      $display("FAIL stall_resume: writes=%0d grant=%b want 3 0000", writes, grant);
    end
    req = 4'b0000;
  endtask

  task automatic test_full_idle();
    do_reset();
    fifo_full = 1'b1;
    req = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      step();
      tests++;
      if (grant !== 4'b0 || fifo_write !== 1'b0) begin
        fails++;
        $display("FAIL full_idle%0d: grant=%b write=%b want 0000 0", s, grant, fifo_write);
      end
    end
    fifo_full = 1'b0;
    step();
    tests++;
    if (grant !== 4'b0100) begin fails++; $display("FAIL full_idle_grant: grant=%b want 0100", grant); end
    req = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1111;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if ({grant, busy, fifo_write} !== 6'b0) begin
      fails++;
      $display("FAIL async_reset: grant=%b busy=%b write=%b want all 0", grant, busy, fifo_write);
    end
`ifdef FIFO_ARB_GRANT_CNT_EN
    tests++;
    if (grant_cnt !== 16'd0) begin fails++; $display("FAIL async_grant_cnt: %0d want 0", grant_cnt); end
`endif
    @(negedge clock);
    rst = 1'b1;
    req = 4'b1000;
    step();
    tests++;
    if (grant !== 4'b1000) begin fails++; $display("FAIL async_regrant: grant=%b want 1000", grant); end
    do_reset();
    req = 4'b1010;
    step();
    tests++;
    if (grant !== 4'b0010) begin fails++; $display("FAIL async_priority: grant=%b want 0010", grant); end
    req = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_stall();
    test_full_idle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
